router_pkt_tx: RTL
==================

Name: router_pkt_tx

Overview:
- Packet transmitter for the 1x3 router's write-side protocol. It sources the pkt_valid/data_in stream that the router consumes and obeys the router's busy/error responses.
- Payload bytes are buffered internally first, so every packet goes out gap-free once a command is accepted.
- It sits between a host/test-harness byte source and the router input port, and replaces the bench write driver in synthesizable system tests.

Parameters:
- DEPTH, 64, payload buffer entries (power of 2, ≥63).
- CHK_CYCLES, 3, cycles after the parity byte during which router error is sampled.

Ports:
- clock  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- pl_valid  in  1  payload byte push request
- pl_data  in  8  payload byte
- pl_ready  out  1  buffer not full
- cmd_valid  in  1  send-packet request
- cmd_addr  in  2  destination port 0..2
- cmd_len  in  6  payload length 0..63
- cmd_bad_par  in  1  inject inverted parity byte
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid
- pkt_valid  out  1  to router
- data_in  out  8  to router
- busy  in  1  from router
- error  in  1  from router
- tx_done  out  1  one-cycle pulse, packet finished
- tx_err  out  1  one-cycle pulse with tx_done, router flagged error
- cmd_rej  out  1  one-cycle pulse, cmd_addr==3 rejected
- level  out  7  buffered payload byte count

Behaviour:
- Reset values: pkt_valid=0, data_in=0, tx_done=0, tx_err=0, cmd_rej=0, level=0, buffer flushed, FSM=IDLE. While resetn=0, cmd_ready=0 and pl_ready=0.
- Reset asserted mid-packet aborts the packet immediately: pkt_valid drops asynchronously and the buffer is flushed.
- Buffer:
  - Push happens when pl_valid && pl_ready.
  - pl_ready = (level<DEPTH).
  - Push and pop in the same cycle leave level unchanged.
  - Pops occur only in PAYLOAD.
- cmd_ready = (state==IDLE) && (level ≥ cmd_len). This is combinational on cmd_len, by design.
- Accept with cmd_addr==3:
  - cmd_rej pulses the next cycle.
  - No bytes are sent and no payload is consumed.
  - FSM stays IDLE.
- Accept with a valid address latches addr, len and bad_par, and goes to HEADER.
- All router-facing outputs are registered.
- FSM states:
  - IDLE: pkt_valid=0, data_in=0.
  - HEADER: data_in={len,addr}, pkt_valid=1. Appears the cycle after accept. The running parity is initialised to the header byte.
  - PAYLOAD: one byte per advancing cycle, pkt_valid=1, parity ^= byte. Exits after len bytes. len==0 skips directly to PARITY.
  - PARITY: data_in=parity (bitwise inverted if bad_par), pkt_valid=0.
  - CHECK: counts CHK_CYCLES cycles. Any error==1 sampled in PARITY or CHECK sets a sticky flag. At the final CHECK cycle the FSM returns to IDLE with tx_done=1 and tx_err=flag.
- Busy handling:
  - If busy==1 at a rising edge in HEADER, PAYLOAD or PARITY, the state, data_in, pkt_valid, buffer and parity all hold.
  - The transfer advances only on edges where busy==0.
  - busy is ignored in IDLE and CHECK.
- Simultaneous cmd_valid with tx_done: a new command is not accepted until the cycle after tx_done, so there is at least one IDLE cycle between packets.
- Total packet time with no busy: len+2 byte cycles plus CHK_CYCLES.

Test Plan:
- Push A5,3C; cmd addr=1 len=2 -> data_in 09,A5,3C with pkt_valid=1, then 90 with pkt_valid=0. tx_done pulses 3 cycles later with tx_err=0 and level=0.
- Same packet with busy held high for 4 cycles during payload byte A5 -> A5 held stable for exactly those cycles, and the sequence and parity are unchanged.
- cmd_bad_par=1, router returns error=1 in CHECK -> parity byte 6F, tx_done with tx_err=1.
- Buffer holds 1 byte, cmd len=5 -> cmd_ready stays 0 until level reaches 5, then the packet is sent. cmd addr=3 -> cmd_rej pulses and level is unchanged.
- len=0, addr=2 -> header 02, parity 02, pkt_valid high 1 cycle. Push 64 bytes -> pl_ready=0 at level 64.
- resetn pulsed low mid-payload -> pkt_valid=0 immediately, level=0, FSM in IDLE, and the next packet is correct.

Source files
------------

// File: rtl/router_pkt_tx.sv
// Packet transmitter for the 1x3 router write side: buffers payload bytes, then sends
// header, payload and parity gap-free and reports the router's error verdict.
module router_pkt_tx #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned CHK_CYCLES = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pl_valid,
    input  logic [7:0] pl_data,
    output logic       pl_ready,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic       cmd_bad_par,
    output logic       cmd_ready,
    output logic       pkt_valid,
    output logic [7:0] data_in,
    input  logic       busy,
    input  logic       error,
    output logic       tx_done,
    output logic       tx_err,
    output logic       cmd_rej,
    output logic [6:0] level
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned CW       = (CHK_CYCLES > 1) ? $clog2(CHK_CYCLES) : 1;
    localparam logic [6:0]  DepthLvl = 7'(DEPTH);
    localparam logic [CW-1:0] ChkLast = CW'(CHK_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StHeader, StPayload, StParity, StCheck} state_e;

    state_e state_q, state_d;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_next;
    logic [6:0]    level_q;
    logic [5:0]    len_q, cnt_q, cnt_d;
    logic          bad_par_q;
    logic [CW-1:0] chk_q, chk_d;
    logic [7:0]    parity_q, parity_d, data_q, data_d, last_par;
    logic          err_flag_q, err_flag_d;
    logic          pkt_valid_q, pkt_valid_d;
    logic          tx_done_q, tx_done_d, tx_err_q, tx_err_d, cmd_rej_q, cmd_rej_d;
    logic          push, pop, accept, start, last_byte, chk_last;

    assign rd_next   = rd_ptr_q + AW'(1);
    assign push      = pl_valid && pl_ready;
    assign accept    = cmd_valid && cmd_ready;
    assign start     = accept && (cmd_addr != 2'd3);
    assign last_byte = (cnt_q == len_q - 6'd1);
    assign chk_last  = (chk_q == ChkLast);
    // Parity including the byte currently on the wire, inverted on request.
    assign last_par  = parity_q ^ data_q ^ {8{bad_par_q}};

    assign pl_ready  = resetn && (level_q < DepthLvl);
    // No accept during the tx_done cycle guarantees an idle gap between packets.
    assign cmd_ready = resetn && (state_q == StIdle) && !tx_done_q &&
                       (level_q >= {1'b0, cmd_len});

    assign pkt_valid = pkt_valid_q;
    assign data_in   = data_q;
    assign tx_done   = tx_done_q;
    assign tx_err    = tx_err_q;
    assign cmd_rej   = cmd_rej_q;
    assign level     = level_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start) state_d = StHeader;
            StHeader:  if (!busy) state_d = (len_q == 6'd0) ? StParity : StPayload;
            StPayload: if (!busy && last_byte) state_d = StParity;
            StParity:  if (!busy) state_d = StCheck;
            StCheck:   if (chk_last) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        pop         = 1'b0;
        pkt_valid_d = pkt_valid_q;
        data_d      = data_q;
        parity_d    = parity_q;
        cnt_d       = cnt_q;
        chk_d       = chk_q;
        err_flag_d  = err_flag_q;
        tx_done_d   = 1'b0;
        tx_err_d    = 1'b0;
        cmd_rej_d   = 1'b0;
        case (state_q)
            StIdle: begin
                pkt_valid_d = 1'b0;
                data_d      = 8'h00;
                cnt_d       = 6'd0;
                chk_d       = '0;
                err_flag_d  = 1'b0;
                if (accept && !start) begin
                    cmd_rej_d = 1'b1;
                end else if (start) begin
                    pkt_valid_d = 1'b1;
                    data_d      = {cmd_len, cmd_addr};
                    parity_d    = {cmd_len, cmd_addr};
                end
            end
            StHeader: begin
                if (!busy) begin
                    if (len_q == 6'd0) begin
                        pkt_valid_d = 1'b0;
                        data_d      = parity_q ^ {8{bad_par_q}};
                    end else begin
                        data_d = mem[rd_ptr_q];
                    end
                end
            end
            StPayload: begin
                // The byte on the wire stays in the buffer until the router takes it.
                if (!busy) begin
                    pop      = 1'b1;
                    parity_d = parity_q ^ data_q;
                    cnt_d    = cnt_q + 6'd1;
                    if (last_byte) begin
                        pkt_valid_d = 1'b0;
                        data_d      = last_par;
                    end else begin
                        data_d = mem[rd_next];
                    end
                end
            end
            StParity: begin
                err_flag_d = err_flag_q | error;
                if (!busy) begin
                    data_d = 8'h00;
                end
            end
            StCheck: begin
                err_flag_d = err_flag_q | error;
                chk_d      = chk_q + CW'(1);
                if (chk_last) begin
                    tx_done_d = 1'b1;
                    tx_err_d  = err_flag_q | error;
                    chk_d     = '0;
                end
            end
            default: begin
                pkt_valid_d = 1'b0;
                data_d      = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= 7'd0;
            len_q       <= 6'd0;
            bad_par_q   <= 1'b0;
            cnt_q       <= 6'd0;
            chk_q       <= '0;
            parity_q    <= 8'h00;
            err_flag_q  <= 1'b0;
            pkt_valid_q <= 1'b0;
            data_q      <= 8'h00;
            tx_done_q   <= 1'b0;
            tx_err_q    <= 1'b0;
            cmd_rej_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_next;
            end
            level_q <= level_q + 7'(push) - 7'(pop);
            if (start) begin
                len_q     <= cmd_len;
                bad_par_q <= cmd_bad_par;
            end
            cnt_q       <= cnt_d;
            chk_q       <= chk_d;
            parity_q    <= parity_d;
            err_flag_q  <= err_flag_d;
            pkt_valid_q <= pkt_valid_d;
            data_q      <= data_d;
            tx_done_q   <= tx_done_d;
            tx_err_q    <= tx_err_d;
            cmd_rej_q   <= cmd_rej_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= pl_data;
        end
    end

endmodule
